// File: rtl/rr_slice_scheduler_if.sv
// Requester/config/grant bundle for the round-robin slice scheduler.
// master = requesters + control block, slave = scheduler.
interface rr_slice_scheduler_if #(
  parameter int N     = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 4
);
  logic [N-1:0]     req;
  logic             cfg_we;
  logic [IDW-1:0]   cfg_idx;
  logic [CNT_W-1:0] cfg_len;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic [CNT_W-1:0] slice_cnt;
  logic             slice_last;

  modport master (
    output req, cfg_we, cfg_idx, cfg_len,
    input  gnt, gnt_valid, gnt_id, slice_cnt, slice_last
  );

  modport slave (
    input  req, cfg_we, cfg_idx, cfg_len,
    output gnt, gnt_valid, gnt_id, slice_cnt, slice_last
  );
endinterface

// File: rtl/rr_slice_scheduler.sv
// Round-robin time-slice scheduler: one owner at a time, each holding the
// resource for its programmed slice length or until it drops req.
module rr_slice_scheduler #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int CNT_W     = 4,
  parameter int DEF_SLICE = 4
) (
  input logic                 clk,
  input logic                 rst,
  rr_slice_scheduler_if.slave sif
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                     state_q, state_d;
  logic [IDW-1:0]             id_q, id_d;
  logic [IDW-1:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [N-1:0][CNT_W-1:0]    len_q;

  logic                       hi_found, lo_found, win_found;
  logic [IDW-1:0]             hi_id, lo_id, win_id;
  logic [CNT_W-1:0]           win_len;
  logic                       slice_end;

  // Per-requester slice length; out-of-range cfg_idx matches no entry.
  for (genvar g = 0; g < N; g++) begin : g_len
    always_ff @(posedge clk) begin
      if (rst)
        len_q[g] <= CNT_W'(DEF_SLICE);
      else if (sif.cfg_we && sif.cfg_idx == IDW'(g))
        len_q[g] <= sif.cfg_len;
    end
  end

  // Rotating priority: lowest requester above ptr first, else lowest at or
  // below ptr, which puts the previous owner (ptr) last in line.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (sif.req[i]) begin
        if (i > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = IDW'(i);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
    win_len   = (len_q[win_id] == '0) ? CNT_W'(1) : len_q[win_id];
  end

  assign slice_end = (cnt_q == CNT_W'(1)) || !sif.req[id_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= IDW'(N-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          id_d    = win_id;
          ptr_d   = win_id;
          cnt_d   = win_len;
        end
      end
      GRANT: begin
        if (!slice_end) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (win_found) begin
          id_d  = win_id;
          ptr_d = win_id;
          cnt_d = win_len;
        end else begin
          state_d = IDLE;
          id_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sif.gnt        = '0;
    sif.gnt_valid  = 1'b0;
    sif.slice_last = 1'b0;
    if (state_q == GRANT) begin
      sif.gnt[id_q]  = 1'b1;
      sif.gnt_valid  = 1'b1;
      sif.slice_last = (cnt_q == CNT_W'(1));
    end
    sif.gnt_id    = id_q;
    sif.slice_cnt = cnt_q;
  end

endmodule

// File: tb/tb_rr_slice_scheduler.sv
// Directed vector bench for rr_slice_scheduler (N=4, CNT_W=4, DEF_SLICE=4).
module tb_rr_slice_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_slice_scheduler_if #(.N(4), .IDW(2), .CNT_W(4)) sif ();

  rr_slice_scheduler #(.N(4), .IDW(2), .CNT_W(4), .DEF_SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       we;
    logic [1:0] idx;
    logic [3:0] len;
    logic [3:0] egnt;
    logic [1:0] eid;
    logic [3:0] ecnt;
    logic       elast;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic [3:0] q, logic w, logic [1:0] ix,
                              logic [3:0] ln, logic [3:0] g, logic [1:0] id,
                              logic [3:0] c, logic l);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.idx = ix; v.len = ln;
    v.egnt = g; v.eid = id; v.ecnt = c; v.elast = l;
    return v;
  endfunction

  task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [3:0] q, logic w, logic [1:0] ix, logic [3:0] ln);
    rst = r; sif.req = q; sif.cfg_we = w; sif.cfg_idx = ix; sif.cfg_len = ln;
  endtask

  initial begin
    bit seen;
    drive(1'b1, 4'b0, 1'b0, 2'd0, 4'd0);

    // reset, then requester 0 alone: back-to-back 4-cycle slices
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 4, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 3, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 2, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 4, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 3, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    // program lengths 3,2,1,4 while idle
    vecs.push_back(mk(0, 4'b0000, 1, 0, 3, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 2, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 3, 4, 4'b0000, 0, 0, 0));
    // all requesting; last owner was 0 so rotation starts at 1
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 1, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0100, 2, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 3, 4, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 3, 3, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 3, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 3, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 3, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 1, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0100, 2, 1, 1));
    // req=0011, requester 0 releases in cycle 2 of its slice
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 4'b0001, 0, 3, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 4'b0001, 0, 2, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 2, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    // zero length on requester 2 behaves as 1
    vecs.push_back(mk(0, 4'b0000, 1, 2, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 2, 1, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 2, 1, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 2, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    // len 7 written to requester 0 mid-slice: only the next slice uses it
    vecs.push_back(mk(0, 4'b0000, 1, 0, 4, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 4, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 0, 7, 4'b0001, 0, 3, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 2, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 7, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 0, 6, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    // cfg write coinciding with grant load for the same index uses old length
    vecs.push_back(mk(0, 4'b0010, 1, 1, 5, 4'b0010, 1, 2, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 5, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    // reset mid-slice restores defaults and pointer
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0100, 2, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 3, 4, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 3, 3, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 4, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 3, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 1, 4, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].rst, vecs[n].req, vecs[n].we, vecs[n].idx, vecs[n].len);
      @(posedge clk); #1;
      chk("gnt",        n, 32'(sif.gnt),        32'(vecs[n].egnt));
      chk("gnt_valid",  n, 32'(sif.gnt_valid),  32'(vecs[n].egnt != 4'b0));
      chk("gnt_id",     n, 32'(sif.gnt_id),     32'(vecs[n].eid));
      chk("slice_cnt",  n, 32'(sif.slice_cnt),  32'(vecs[n].ecnt));
      chk("slice_last", n, 32'(sif.slice_last), 32'(vecs[n].elast));
    end

    // starvation bound: all request, requester 3 must own within 3*4 cycles
    drive(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0);
    seen = 1'b0;
    for (int c = 0; c < 13 && !seen; c++) begin
      @(posedge clk); #1;
      if (sif.gnt == 4'b1000) seen = 1'b1;
      chk("no_bubble", c, 32'(sif.gnt_valid), 32'd1);
    end
    chk("starve_bound", 0, 32'(seen), 32'd1);

    // early release of a 4-cycle slice after one cycle, then idle
    drive(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0);
    @(posedge clk); #1;
    drive(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
    @(posedge clk); #1;
    chk("early_gnt", 0, 32'(sif.gnt), 32'h1);
    drive(1'b0, 4'b0000, 1'b0, 2'd0, 4'd0);
    @(posedge clk); #1;
    chk("early_idle", 0, 32'(sif.gnt), 32'h0);
    chk("early_cnt",  0, 32'(sif.slice_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_slice_scheduler.md
Name: rr_slice_scheduler

Overview:
- Round-robin time-slice scheduler that shares one resource among N requesters.
- Each grant is held for a programmable slice length per requester, unless the owner releases early.
- Grants pass with zero bubble cycles when another request is pending.
- Sits between the requesting masters and the shared datapath. A small config port, written by the control block, sets each requester's slice length.

Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, width of grant index, equal to clog2(N)
- CNT_W, 4, slice counter width; maximum slice is 2^CNT_W-1 cycles
- DEF_SLICE, 4, reset slice length for every requester

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req  in  N  request vector; bit i held high while requester i wants the resource
- cfg_we  in  1  config write strobe
- cfg_idx  in  IDW  requester whose slice length is written
- cfg_len  in  CNT_W  new slice length in cycles
- gnt  out  N  one-hot grant, registered; all zeros when idle
- gnt_valid  out  1  high whenever gnt is nonzero
- gnt_id  out  IDW  binary index of current owner; 0 when idle
- slice_cnt  out  CNT_W  remaining cycles in current slice, including the current cycle; 0 when idle
- slice_last  out  1  high in the final counted cycle of a slice (GRANT and slice_cnt==1)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - gnt=0, gnt_valid=0, gnt_id=0, slice_cnt=0, slice_last=0.
  - State=IDLE.
  - RR pointer = N-1, so req[0] has first priority.
  - All slice lengths = DEF_SLICE.
- Reset mid-slice drops the grant at the next edge and restores the config defaults.
- States:
  - IDLE: no owner.
  - GRANT: one owner, counting down.
- Effective length: len_eff(i) = slice_len[i] when nonzero, else 1. A programmed length of 0 is treated as 1.
- Winner search: scan from (ptr+1) mod N upward with wrap-around. The first i with req[i]=1 wins. The previous owner is searched last, so it only wins again when no other requester is pending.
- IDLE:
  - If req != 0 at an edge, go to GRANT with gnt=onehot(winner), gnt_id=winner, slice_cnt=len_eff(winner), ptr=winner.
  - Latency from req rise to gnt is 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT:
  - end = (slice_cnt==1) OR (req[gnt_id]==0).
  - If end is 0 at an edge: slice_cnt decrements; gnt is unchanged.
  - If end is 1 at an edge, a winner search runs over current req (owner bit included only if still high):
    - winner found: next grant loads in the same edge (no idle cycle between owners); ptr=winner; slice_cnt=len_eff(winner).
    - no winner: go to IDLE with gnt=0 and slice_cnt=0; ptr keeps the last owner.
- Owner continuity: an owner holding req high for exactly len_eff cycles sees gnt for exactly len_eff consecutive cycles.
- Early release: req[owner] sampled low ends the slice at that edge. The owner may therefore see gnt for one cycle after it drops req.
- Config:
  - cfg_we writes slice_len[cfg_idx] <= cfg_len at the edge.
  - The length is latched into slice_cnt only at grant start, so a write during an active slice affects only later slices, including the owner's own.
  - When cfg_we and a grant load coincide for the same index, the grant uses the old value.
  - cfg_idx >= N: write is ignored.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - No requester is granted without its req high at the granting edge.
- Starvation bound: a continuously requesting i waits at most the sum over j≠i of len_eff(j) cycles.

Test Plan:
- Reset, then req=0001 held: gnt=0001 from cycle 1, re-granted back-to-back every 4 cycles. slice_last pulses every 4th cycle. gnt_valid stays high.
- Lengths 3,2,1,4 programmed; req=1111 held: gnt sequence is 0001×3, 0010×2, 0100×1, 1000×4, then repeats. Gnt never goes to zero.
- req=0011, req[0] dropped in cycle 2 of its slice: gnt moves to 0010 at the next edge; slice_cnt reloads to len_eff(1).
- cfg_len=0 for requester 2; req=0100: gnt=0100 re-granted every cycle with slice_cnt=1 and slice_last constantly high.
- Write len=7 to requester 0 while it owns a 4-cycle slice: the current slice still lasts 4 cycles; the next slice for requester 0 lasts 7.
- rst pulsed mid-slice with req=1111: outputs are zero the cycle after. With rst low again, gnt=0001 one cycle later and lengths are back to DEF_SLICE. All req dropped afterwards: IDLE with gnt=0 after the owner's release edge.
